// File: rtl/lfsr_updown_checker_pkg.sv
// Shared defaults and FSM state type for the LFSR up/down checker and its
// combinational step helper.
package lfsr_updown_checker_pkg;

  localparam int unsigned    DEF_WIDTH = 8;
  localparam logic [7:0]     DEF_TAPS  = 8'hB8;
  localparam logic [7:0]     DEF_SEED  = 8'h00;
  localparam int unsigned    DEF_ERR_W = 8;

  typedef enum logic {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } state_t;

endpackage

// File: rtl/lfsr_updown_checker_step.sv
// Combinational LFSR step: dir=1 gives next(s), dir=0 gives prev(s).
// XNOR feedback, so all-ones is the lockup state and has no valid neighbour.
module lfsr_step
  import lfsr_updown_checker_pkg::*;
#(
  parameter int unsigned           WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0]      TAPS  = WIDTH'(DEF_TAPS)
) (
  input  logic [WIDTH-1:0] s,
  input  logic             dir,
  output logic [WIDTH-1:0] step
);

  logic fwd_bit;
  logic back_bit;

  always_comb begin
    fwd_bit  = ~^(s & TAPS);
    // Recover the bit shifted out: it is the one whose removal makes the
    // feedback equation hold for the bit shifted in (now s[0]).
    back_bit = ~s[0] ^ (^(s[WIDTH-1:1] & TAPS[WIDTH-2:0]));
    if (dir) step = {s[WIDTH-2:0], fwd_bit};
    else     step = {back_bit, s[WIDTH-1:1]};
  end

endmodule

// File: rtl/lfsr_updown_checker.sv
// Receive-side checker for an up/down LFSR counter: locks on SEED, verifies
// every enabled step, tracks binary position and counts errors.
module lfsr_updown_checker
  import lfsr_updown_checker_pkg::*;
#(
  parameter int unsigned           WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0]      TAPS  = WIDTH'(DEF_TAPS),
  parameter logic [WIDTH-1:0]      SEED  = WIDTH'(DEF_SEED),
  parameter int unsigned           ERR_W = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic [WIDTH-1:0] count,
  output logic             locked,
  output logic [WIDTH-1:0] position,
  output logic             match,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] POS_MAX = {{(WIDTH-1){1'b1}}, 1'b0};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ref_state, ref_nxt;
  logic [WIDTH-1:0] pos_nxt;
  logic [WIDTH-1:0] exp_word;
  logic [ERR_W-1:0] errc_nxt;
  logic             match_nxt, err_nxt, wrap_nxt;
  logic             illegal;

  lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .s    (ref_state),
    .dir  (up_down),
    .step (exp_word)
  );

  assign illegal = (count == '1);
  assign locked  = (state == TRACK);

  always_comb begin
    state_nxt = state;
    ref_nxt   = ref_state;
    pos_nxt   = position;
    errc_nxt  = err_count;
    match_nxt = 1'b0;
    err_nxt   = 1'b0;
    wrap_nxt  = 1'b0;
    if (enable) begin
      if (illegal || (state == TRACK && count != exp_word)) begin
        err_nxt   = 1'b1;
        state_nxt = ACQUIRE;
        pos_nxt   = '0;
        if (err_count != '1) errc_nxt = err_count + ERR_W'(1);
      end else if (state == ACQUIRE) begin
        if (count == SEED) begin
          state_nxt = TRACK;
          ref_nxt   = count;
          pos_nxt   = '0;
        end
      end else begin
        match_nxt = 1'b1;
        ref_nxt   = count;
        if (up_down) begin
          wrap_nxt = (position == POS_MAX);
          pos_nxt  = (position == POS_MAX) ? '0 : position + WIDTH'(1);
        end else begin
          wrap_nxt = (position == '0);
          pos_nxt  = (position == '0) ? POS_MAX : position - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACQUIRE;
      ref_state <= SEED;
      position  <= '0;
      match     <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_nxt;
      ref_state <= ref_nxt;
      position  <= pos_nxt;
      match     <= match_nxt;
      err       <= err_nxt;
      err_count <= errc_nxt;
      wrap      <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_lfsr_updown_checker.sv
// Bench for lfsr_updown_checker: directed scenarios then random traffic,
// checked against a sequence-table model of the LFSR orbit.
module tb_lfsr_updown_checker;

  localparam int PER = 255;

  logic       clk = 1'b0;
  logic       reset, enable, up_down;
  logic [7:0] count;
  logic       locked, match, err, wrap;
  logic [7:0] position, err_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] seq [PER];
  bit         m_locked;
  int         m_pos, m_errc;
  bit         e_match, e_err, e_wrap;
  logic [7:0] last_word;
  int         wraps;

  always #5 clk = ~clk;

  lfsr_updown_checker #(
    .WIDTH (8),
    .TAPS  (8'hB8),
    .SEED  (8'h00),
    .ERR_W (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .up_down   (up_down),
    .count     (count),
    .locked    (locked),
    .position  (position),
    .match     (match),
    .err       (err),
    .err_count (err_count),
    .wrap      (wrap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, then update the model and compare every output.
  task automatic step(input bit rst, input bit en, input bit ud, input logic [7:0] c);
    int np;
    reset = rst; enable = en; up_down = ud; count = c;
    @(posedge clk); #1;
    e_match = 0; e_err = 0; e_wrap = 0;
    if (rst) begin
      m_locked = 0; m_pos = 0; m_errc = 0;
    end else if (en) begin
      np = ud ? (m_pos + 1) % PER : (m_pos + PER - 1) % PER;
      if (c == 8'hFF || (m_locked && c != seq[np])) begin
        e_err = 1;
        if (m_errc < 255) m_errc++;
        m_locked = 0; m_pos = 0;
      end else if (!m_locked) begin
        if (c == 8'h00) begin m_locked = 1; m_pos = 0; end
      end else begin
        e_match = 1;
        e_wrap  = ud ? (np == 0) : (np == PER - 1);
        m_pos   = np;
      end
    end
    if (en && !rst) last_word = c;
    chk("locked",    locked,    m_locked);
    chk("position",  position,  m_pos);
    chk("match",     match,     e_match);
    chk("err",       err,       e_err);
    chk("err_count", err_count, m_errc);
    chk("wrap",      wrap,      e_wrap);
  endtask

  task automatic fwd();
    step(0, 1, 1, seq[(m_pos + 1) % PER]);
  endtask

  task automatic bwd();
    step(0, 1, 0, seq[(m_pos + PER - 1) % PER]);
  endtask

  initial begin
    logic [7:0] s;
    int r;
    s = 8'h00;
    for (int i = 0; i < PER; i++) begin
      seq[i] = s;
      s = {s[6:0], ~^(s & 8'hB8)};
    end
    m_locked = 0; m_pos = 0; m_errc = 0; last_word = 8'h00;

    // 1: reset, acquire, two forward steps
    repeat (10) step(1, 0, 0, 8'h00);
    step(0, 1, 1, 8'h00);
    step(0, 1, 1, 8'h01);
    step(0, 1, 1, 8'h03);
    chk("t1_pos2", position, 8'd2);
    chk("t1_locked", locked, 1'b1);

    // 2: a full period forward, one wrap
    wraps = 0;
    for (int i = 0; i < PER; i++) begin
      fwd();
      if (wrap === 1'b1) wraps++;
      chk("t2_pos_range", (position < 8'd255), 1'b1);
    end
    chk("t2_wraps", wraps, 1);
    chk("t2_pos_back", position, 8'd2);

    // 3: down steps through zero
    step(0, 1, 0, 8'h01);
    step(0, 1, 0, 8'h00);
    chk("t3_pos0", position, 8'd0);
    step(0, 1, 0, 8'h80);
    chk("t3_pos254", position, 8'd254);
    chk("t3_wrap", wrap, 1'b1);

    // 4: injected mismatch and re-acquire
    step(0, 1, 1, 8'h00);
    step(0, 1, 1, 8'h01);
    step(0, 1, 1, 8'h03);
    step(0, 1, 1, 8'h55);
    chk("t4_err", err, 1'b1);
    chk("t4_errc", err_count, 8'd1);
    step(0, 1, 1, 8'h07);
    chk("t4_ignored", locked, 1'b0);
    step(0, 1, 1, 8'h00);
    chk("t4_relock", locked, 1'b1);

    // 5: all-ones in TRACK and ACQUIRE, then a disabled cycle
    fwd();
    step(0, 1, 1, 8'hFF);
    step(0, 1, 1, 8'hFF);
    chk("t5_errc", err_count, 8'd3);
    step(0, 0, 1, 8'h01);
    chk("t5_noerr", err, 1'b0);

    // 6: saturate the error counter, then reset mid-TRACK
    repeat (300) step(0, 1, 1, 8'hFF);
    chk("t6_sat", err_count, 8'hFF);
    step(0, 1, 1, 8'h00);
    repeat (5) fwd();
    step(1, 1, 1, seq[(m_pos + 1) % PER]);
    chk("t6_rst_errc", err_count, 8'd0);
    chk("t6_rst_locked", locked, 1'b0);

    // Random traffic around the orbit
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5)        step(0, 0, 1'($urandom), 8'($urandom));
      else if (r < 9)   step(0, 1, 1'($urandom), 8'hFF);
      else if (r < 14)  step(0, 1, 1'($urandom), last_word);
      else if (r < 19)  step(0, 1, 1'($urandom), 8'($urandom));
      else if (r < 20)  step(1, 0, 0, 8'h00);
      else if (!m_locked) step(0, 1, 1'($urandom), 8'h00);
      else if (r < 60)  fwd();
      else              bwd();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
